// File: rtl/input_cmd_pkg.sv
// Shared key codes, repeat-FSM states and code classification for the keypad decoder.
package input_cmd_pkg;

  localparam int unsigned CODE_W = 4;

  localparam logic [CODE_W-1:0] CODE_USER0  = 4'h0;
  localparam logic [CODE_W-1:0] CODE_USER1  = 4'h1;
  localparam logic [CODE_W-1:0] CODE_USER2  = 4'h2;
  localparam logic [CODE_W-1:0] CODE_USER3  = 4'h3;
  localparam logic [CODE_W-1:0] CODE_RED    = 4'h4;
  localparam logic [CODE_W-1:0] CODE_GREEN  = 4'h5;
  localparam logic [CODE_W-1:0] CODE_BLUE   = 4'h6;
  localparam logic [CODE_W-1:0] CODE_UP     = 4'h7;
  localparam logic [CODE_W-1:0] CODE_DOWN   = 4'h8;
  localparam logic [CODE_W-1:0] CODE_LEFT   = 4'h9;
  localparam logic [CODE_W-1:0] CODE_RIGHT  = 4'hA;
  localparam logic [CODE_W-1:0] CODE_SPD_UP = 4'hB;
  localparam logic [CODE_W-1:0] CODE_SPD_DN = 4'hC;
  localparam logic [CODE_W-1:0] CODE_BG_SEL = 4'hD;
  localparam logic [CODE_W-1:0] CODE_FLASH  = 4'hE;
  localparam logic [CODE_W-1:0] CODE_NOP    = 4'hF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2
  } rpt_state_e;

  // Move keys are the only ones that auto-repeat while held.
  function automatic logic is_move_code(input logic [CODE_W-1:0] code);
    return (code == CODE_UP) || (code == CODE_DOWN) ||
           (code == CODE_LEFT) || (code == CODE_RIGHT);
  endfunction

endpackage

// File: rtl/cmd_repeat_timer.sv
// Press detection and auto-repeat timing; emits a one-cycle execute strobe per command.
module cmd_repeat_timer
  import input_cmd_pkg::*;
#(
  parameter int unsigned REPEAT_DELAY = 2000,
  parameter int unsigned REPEAT_RATE  = 500
) (
  input  logic              clock,
  input  logic              resetN,
  input  logic              in_valid,
  input  logic [CODE_W-1:0] in_code,
  output logic              exec_c,
  output logic [CODE_W-1:0] code_c
);

  localparam int unsigned CNT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX);

  localparam logic [CNT_W-1:0] DELAY_LOAD = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RATE_LOAD  = CNT_W'(REPEAT_RATE - 1);

  rpt_state_e        state, state_nxt;
  logic [CNT_W-1:0]  rpt_cnt, rpt_cnt_nxt;
  logic [CODE_W-1:0] last_code, last_code_nxt;

  // The executed code is always the one on the input this cycle.
  assign code_c = in_code;

  // State, counter and last-executed-code registers.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state     <= IDLE;
      rpt_cnt   <= '0;
      last_code <= '0;
    end else begin
      state     <= state_nxt;
      rpt_cnt   <= rpt_cnt_nxt;
      last_code <= last_code_nxt;
    end
  end

  // Next state and execute strobe: new presses, code changes and timed repeats.
  always_comb begin
    state_nxt     = state;
    rpt_cnt_nxt   = rpt_cnt;
    last_code_nxt = last_code;
    exec_c        = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          exec_c        = 1'b1;
          last_code_nxt = in_code;
          rpt_cnt_nxt   = DELAY_LOAD;
          state_nxt     = HOLD;
        end
      end
      HOLD, REPEAT: begin
        if (!in_valid) begin
          state_nxt = IDLE;
        end else if (in_code != last_code) begin
          exec_c        = 1'b1;
          last_code_nxt = in_code;
          rpt_cnt_nxt   = DELAY_LOAD;
          state_nxt     = HOLD;
        end else if (rpt_cnt == '0) begin
          // Non-move keys park here with the counter frozen at zero.
          if ((state == REPEAT) || is_move_code(last_code)) begin
            exec_c      = 1'b1;
            rpt_cnt_nxt = RATE_LOAD;
            state_nxt   = REPEAT;
          end
        end else begin
          rpt_cnt_nxt = rpt_cnt - 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: rtl/input_cmd_decoder.sv
// Keypad command decoder: user number, speed, colours, move pulses and flash strobe.
module input_cmd_decoder
  import input_cmd_pkg::*;
#(
  parameter int unsigned COLOR_BITS   = 3,
  parameter int unsigned SPEED_MIN    = 1,
  parameter int unsigned SPEED_MAX    = 4,
  parameter int unsigned SPEED_WRAP   = 1,
  parameter int unsigned REPEAT_DELAY = 2000,
  parameter int unsigned REPEAT_RATE  = 500,
  parameter int unsigned FLASH_DIV    = 25000
) (
  input  logic                    clock,
  input  logic                    resetN,
  input  logic                    inValid,
  input  logic [3:0]              inCode,
  output logic [2:0]              userNum,
  output logic [3:0]              movSpeed,
  output logic [3*COLOR_BITS-1:0] charRGB,
  output logic [3*COLOR_BITS-1:0] bgRGB,
  output logic [3:0]              charOffset,
  output logic                    enBg,
  output logic                    flashClk
);

  localparam int unsigned RGB_W  = 3 * COLOR_BITS;
  localparam int unsigned FDIV_W = $clog2(FLASH_DIV);

  localparam logic [3:0]        SPD_MIN  = 4'(SPEED_MIN);
  localparam logic [3:0]        SPD_MAX  = 4'(SPEED_MAX);
  localparam logic [FDIV_W-1:0] FDIV_TOP = FDIV_W'(FLASH_DIV - 1);

  logic              exec_c;
  logic [CODE_W-1:0] code_c;

  logic [2:0]        user_nxt;
  logic [3:0]        speed_nxt;
  logic [RGB_W-1:0]  char_nxt, bg_nxt, stepped;
  logic [3:0]        offset_nxt;
  logic              en_bg_nxt;
  logic              flash_en, flash_en_nxt;
  logic              color_step, flash_restart;
  logic [FDIV_W-1:0] flash_div;

  cmd_repeat_timer #(
    .REPEAT_DELAY (REPEAT_DELAY),
    .REPEAT_RATE  (REPEAT_RATE)
  ) u_timer (
    .clock    (clock),
    .resetN   (resetN),
    .in_valid (inValid),
    .in_code  (inCode),
    .exec_c   (exec_c),
    .code_c   (code_c)
  );

  // Decode the executed code into next values of the control registers.
  always_comb begin
    user_nxt      = userNum;
    speed_nxt     = movSpeed;
    char_nxt      = charRGB;
    bg_nxt        = bgRGB;
    offset_nxt    = '0;
    en_bg_nxt     = enBg;
    flash_en_nxt  = flash_en;
    flash_restart = 1'b0;
    color_step    = 1'b0;
    stepped       = enBg ? bgRGB : charRGB;
    if (exec_c) begin
      case (code_c)
        CODE_USER0, CODE_USER1, CODE_USER2, CODE_USER3:
          user_nxt = {1'b0, code_c[1:0]};
        CODE_RED: begin
          color_step = 1'b1;
          stepped[2*COLOR_BITS +: COLOR_BITS] = stepped[2*COLOR_BITS +: COLOR_BITS] + COLOR_BITS'(1);
        end
        CODE_GREEN: begin
          color_step = 1'b1;
          stepped[COLOR_BITS +: COLOR_BITS] = stepped[COLOR_BITS +: COLOR_BITS] + COLOR_BITS'(1);
        end
        CODE_BLUE: begin
          color_step = 1'b1;
          stepped[0 +: COLOR_BITS] = stepped[0 +: COLOR_BITS] + COLOR_BITS'(1);
        end
        CODE_UP:    offset_nxt = 4'b0001;
        CODE_DOWN:  offset_nxt = 4'b0010;
        CODE_LEFT:  offset_nxt = 4'b0100;
        CODE_RIGHT: offset_nxt = 4'b1000;
        CODE_SPD_UP: begin
          if (movSpeed >= SPD_MAX) speed_nxt = (SPEED_WRAP != 0) ? SPD_MIN : SPD_MAX;
          else                     speed_nxt = movSpeed + 4'd1;
        end
        CODE_SPD_DN: begin
          if (movSpeed <= SPD_MIN) speed_nxt = (SPEED_WRAP != 0) ? SPD_MAX : SPD_MIN;
          else                     speed_nxt = movSpeed - 4'd1;
        end
        CODE_BG_SEL: en_bg_nxt = ~enBg;
        CODE_FLASH: begin
          flash_en_nxt  = ~flash_en;
          flash_restart = 1'b1;
        end
        default: ;
      endcase
    end
    if (color_step) begin
      if (enBg) bg_nxt   = stepped;
      else      char_nxt = stepped;
    end
  end

  // Control registers updated from the decode.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      userNum    <= 3'b100;
      movSpeed   <= SPD_MIN;
      charRGB    <= '1;
      bgRGB      <= '0;
      charOffset <= '0;
      enBg       <= 1'b0;
      flash_en   <= 1'b0;
    end else begin
      userNum    <= user_nxt;
      movSpeed   <= speed_nxt;
      charRGB    <= char_nxt;
      bgRGB      <= bg_nxt;
      charOffset <= offset_nxt;
      enBg       <= en_bg_nxt;
      flash_en   <= flash_en_nxt;
    end
  end

  // Flash divider: toggles flashClk every FLASH_DIV cycles, restarts low on any enable change.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      flash_div <= '0;
      flashClk  <= 1'b0;
    end else if (flash_restart || !flash_en) begin
      flash_div <= '0;
      flashClk  <= 1'b0;
    end else if (flash_div == FDIV_TOP) begin
      flash_div <= '0;
      flashClk  <= ~flashClk;
    end else begin
      flash_div <= flash_div + 1'b1;
    end
  end

endmodule
